// File: rtl/seq_gen_serial.sv
// Serial pattern generator: shifts out pattern[len-1:0] MSB-first, reps+1 times,
// then pulses done for one cycle. Illegal lengths are rejected with an err pulse.
module seq_gen_serial #(
   parameter int unsigned PW = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [PW-1:0]         pattern,
   input  logic [$clog2(PW):0]   len,
   input  logic [3:0]            reps,
   output logic                  dout,
   output logic                  dout_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned LW = $clog2(PW) + 1;
   localparam int unsigned IW = $clog2(PW);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   pat_q;
   logic [LW-1:0]   len_q;
   logic [3:0]      reps_q;
   logic [IW-1:0]   idx;
   logic [3:0]      rep_cnt;
   logic            fin;
   logic            len_ok_c;

   assign len_ok_c = (len != '0) && (len <= LW'(PW));

   // The entry edge only loads; bits start on the following edge, and the
   // cycle showing the last bit is still SHIFT (fin set) before DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pat_q      <= '0;
         len_q      <= '0;
         reps_q     <= '0;
         idx        <= '0;
         rep_cnt    <= '0;
         fin        <= 1'b0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               dout       <= 1'b0;
               dout_valid <= 1'b0;
               busy       <= 1'b0;
               if (start) begin
                  if (len_ok_c) begin
                     pat_q   <= pattern;
                     len_q   <= len;
                     reps_q  <= reps;
                     idx     <= IW'(len - LW'(1));
                     rep_cnt <= '0;
                     fin     <= 1'b0;
                     state   <= SHIFT;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (abort) begin
                  state      <= IDLE;
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
               end else if (fin) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  dout       <= pat_q[idx];
                  dout_valid <= 1'b1;
                  busy       <= 1'b1;
                  if (idx == '0) begin
                     if (rep_cnt == reps_q) begin
                        fin <= 1'b1;
                     end else begin
                        rep_cnt <= rep_cnt + 4'd1;
                        idx     <= IW'(len_q - LW'(1));
                     end
                  end else begin
                     idx <= idx - IW'(1);
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               dout       <= 1'b0;
               dout_valid <= 1'b0;
               busy       <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen_serial.sv
// Self-checking bench for seq_gen_serial: per-cycle expected outputs are queued
// when stimulus is applied and compared one per clock.
module tb_seq_gen_serial;

   localparam int unsigned PW = 16;
   localparam int unsigned LW = $clog2(PW) + 1;

   typedef struct packed {
      logic dout;
      logic dv;
      logic busy;
      logic done;
      logic err;
   } obs_t;

   typedef struct {
      logic [PW-1:0] pattern;
      logic [LW-1:0] len;
      logic [3:0]    reps;
      logic          exp_err;
      int            exp_bits;
   } vec_t;

   localparam obs_t ZERO_O = 5'b00000;
   localparam obs_t DONE_O = 5'b00010;
   localparam obs_t ERR_O  = 5'b00001;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic [PW-1:0] pattern;
   logic [LW-1:0] len;
   logic [3:0]    reps;
   logic          dout, dout_valid, busy, done, err;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   obs_t exp_q[$];
   vec_t vecs[10];

   seq_gen_serial #(.PW(PW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pattern(pattern), .len(len), .reps(reps),
      .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic obs_t bit_o(input logic [PW-1:0] p, input logic [LW-1:0] l, input int k);
      obs_t o;
      int   pos;
      pos    = int'(l) - 1 - (k % int'(l));
      o      = ZERO_O;
      o.dout = p[pos];
      o.dv   = 1'b1;
      o.busy = 1'b1;
      return o;
   endfunction

   // One clock: pop the expectation for this edge and compare after it settles.
   task automatic tick(input string name);
      obs_t e, g;
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      cyc++;
      g = {dout, dout_valid, busy, done, err};
      n_cmp++;
      if (g !== e) begin
         n_bad++;
         $display("FAIL %s cyc %0d: got {dout,dv,busy,done,err}=%b required %b", name, cyc, g, e);
      end
   endtask

   task automatic push_tx(input logic [PW-1:0] p, input logic [LW-1:0] l, input int nbits);
      exp_q.push_back(ZERO_O);
      for (int k = 0; k < nbits; k++) exp_q.push_back(bit_o(p, l, k));
      exp_q.push_back(DONE_O);
      exp_q.push_back(ZERO_O);
   endtask

   task automatic launch(input string name);
      start = 1'b1;
      tick(name);
      start = 1'b0;
      while (exp_q.size() > 0) tick(name);
   endtask

   initial begin
      vecs[0] = '{16'h0005,  5'd3, 4'd0,  1'b0, 3};
      vecs[1] = '{16'h000A,  5'd4, 4'd2,  1'b0, 12};
      vecs[2] = '{16'h1234,  5'd0, 4'd1,  1'b1, 0};
      vecs[3] = '{16'h1234,  5'd17, 4'd0, 1'b1, 0};
      vecs[4] = '{16'h0001,  5'd1, 4'd3,  1'b0, 4};
      vecs[5] = '{16'hFFFE,  5'd1, 4'd2,  1'b0, 3};
      vecs[6] = '{16'hB38F,  5'd16, 4'd0, 1'b0, 16};
      vecs[7] = '{16'h8001,  5'd16, 4'd15, 1'b0, 256};
      vecs[8] = '{16'h00C6,  5'd31, 4'd0, 1'b1, 0};
      vecs[9] = '{16'h0006,  5'd3, 4'd1,  1'b0, 6};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      pattern = '0; len = '0; reps = '0;
      exp_q.push_back(ZERO_O);
      exp_q.push_back(ZERO_O);
      tick("reset");
      tick("reset");
      rst = 1'b0;
      exp_q.push_back(ZERO_O);
      tick("idle");

      foreach (vecs[i]) begin
         pattern = vecs[i].pattern;
         len     = vecs[i].len;
         reps    = vecs[i].reps;
         if (vecs[i].exp_err) begin
            exp_q.push_back(ERR_O);
            exp_q.push_back(ZERO_O);
         end else begin
            push_tx(vecs[i].pattern, vecs[i].len, vecs[i].exp_bits);
         end
         launch($sformatf("vec%0d", i));
      end

      // Inputs change and start re-pulses mid-transmission: no effect.
      pattern = 16'h8001; len = 5'd16; reps = 4'd0;
      push_tx(16'h8001, 5'd16, 16);
      start = 1'b1;
      tick("hold");
      start = 1'b0;
      for (int t = 2; t <= 5; t++) tick("hold");
      pattern = 16'hFFFF; len = 5'd3; reps = 4'd7; start = 1'b1;
      tick("hold");
      start = 1'b0;
      while (exp_q.size() > 0) tick("hold");

      // Abort sampled on the fifth edge after start.
      pattern = 16'h00FF; len = 5'd8; reps = 4'd3;
      exp_q.push_back(ZERO_O);
      for (int k = 0; k < 4; k++) exp_q.push_back(bit_o(16'h00FF, 5'd8, k));
      for (int k = 0; k < 3; k++) exp_q.push_back(ZERO_O);
      start = 1'b1;
      tick("abort");
      start = 1'b0;
      for (int t = 2; t <= 5; t++) tick("abort");
      abort = 1'b1;
      tick("abort");
      abort = 1'b0;
      while (exp_q.size() > 0) tick("abort");
      pattern = 16'h00A5; len = 5'd8; reps = 4'd0;
      push_tx(16'h00A5, 5'd8, 8);
      launch("post_abort");

      // Reset mid-transmission, then reset together with start and abort.
      for (int pass = 0; pass < 2; pass++) begin
         pattern = 16'h00C3; len = 5'd8; reps = 4'd0;
         exp_q.push_back(ZERO_O);
         exp_q.push_back(bit_o(16'h00C3, 5'd8, 0));
         exp_q.push_back(bit_o(16'h00C3, 5'd8, 1));
         exp_q.push_back(ZERO_O);
         exp_q.push_back(ZERO_O);
         start = 1'b1;
         tick("rst_mid");
         start = 1'b0;
         tick("rst_mid");
         tick("rst_mid");
         rst = 1'b1;
         if (pass == 1) begin
            start = 1'b1;
            abort = 1'b1;
         end
         tick("rst_mid");
         rst = 1'b0; start = 1'b0; abort = 1'b0;
         tick("rst_mid");
      end
      pattern = 16'h0035; len = 5'd6; reps = 4'd1;
      push_tx(16'h0035, 5'd6, 12);
      launch("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
